// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment scan bus as seen by the decoder, plus the decoded frame outputs.
// master = bus driver / frame consumer, slave = seg7_scan_decoder.
interface seg7_scan_decoder_if;
  logic [7:0]  seg7;
  logic [3:0]  line;
  logic [15:0] digits;
  logic        frame_valid;
  logic        pat_err;
  logic        line_err;

  modport master (output seg7, line, input digits, frame_valid, pat_err, line_err);
  modport slave  (input seg7, line, output digits, frame_valid, pat_err, line_err);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a 4-digit multiplexed 7-segment scan bus and presents them as
// atomic 16-bit frames once every digit position has been captured.
//
// state  | meaning
// IDLE   | no digit selected (line = 0000), counter held at 0
// SETTLE | digit selected, counting consecutive identical samples
// HELD   | slot captured, waiting for the bus to change
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk0,
  input  logic              rst_n,
  seg7_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]      r_seg_s1, r_seg_s2, r_prev_seg;
  logic [3:0]      r_line_s1, r_line_s2, r_prev_line;
  logic [3:0][3:0] r_shadow;
  logic [3:0]      r_seen;
  logic            r_frame_pend;
  logic [15:0]     r_digits;
  logic            r_frame_valid, r_pat_err, r_line_err;

  logic [3:0] w_code;
  logic       w_code_ok;
  logic       w_onehot;
  logic [1:0] w_idx;
  logic [3:0] w_seen_next;
  logic       w_same;

  always_comb begin
    w_code    = 4'hF;
    w_code_ok = 1'b1;
    case (r_seg_s2)
      7'b0111111: w_code = 4'd0;
      7'b0000110: w_code = 4'd1;
      7'b1011011: w_code = 4'd2;
      7'b1001111: w_code = 4'd3;
      7'b1100110: w_code = 4'd4;
      7'b1101101: w_code = 4'd5;
      7'b1111101: w_code = 4'd6;
      7'b0100111: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1101111: w_code = 4'd9;
      7'b0000000: w_code = 4'hF;
      default:    w_code_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_idx = 2'd0;
    case (r_line_s2)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_onehot    = (r_line_s2 != 4'b0000) && ((r_line_s2 & (r_line_s2 - 4'd1)) == 4'b0000);
  assign w_seen_next = r_seen | (4'b0001 << w_idx);
  assign w_same      = (r_line_s2 == r_prev_line) && (r_seg_s2 == r_prev_seg);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_seg_s1      <= '0;
      r_seg_s2      <= '0;
      r_prev_seg    <= '0;
      r_line_s1     <= '0;
      r_line_s2     <= '0;
      r_prev_line   <= '0;
      r_shadow      <= {4{4'hF}};
      r_seen        <= '0;
      r_frame_pend  <= 1'b0;
      r_digits      <= 16'hFFFF;
      r_frame_valid <= 1'b0;
      r_pat_err     <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_seg_s1      <= bus.seg7[6:0];
      r_seg_s2      <= r_seg_s1;
      r_line_s1     <= bus.line;
      r_line_s2     <= r_line_s1;
      r_prev_seg    <= r_seg_s2;
      r_prev_line   <= r_line_s2;
      r_frame_valid <= 1'b0;
      r_pat_err     <= 1'b0;
      r_line_err    <= 1'b0;

      // Frame load lands one edge after the completing capture so the new shadow value is included.
      if (r_frame_pend) begin
        r_digits      <= r_shadow;
        r_frame_valid <= 1'b1;
        r_seen        <= 4'b0000;
        r_frame_pend  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_line_s2 != 4'b0000) begin
            r_state <= SETTLE;
            r_cnt   <= CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!w_same) begin
            if (r_line_s2 == 4'b0000) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= CNT_W'(1);
            end
          end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_cnt   <= CNT_W'(SETTLE_CYCLES);
            r_state <= HELD;
            if (!w_onehot) begin
              r_line_err <= 1'b1;
            end else if (!w_code_ok) begin
              r_pat_err <= 1'b1;
            end else begin
              r_shadow[w_idx] <= w_code;
              r_seen          <= w_seen_next;
              if (w_seen_next == 4'b1111) r_frame_pend <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!w_same) begin
            if (r_line_s2 == 4'b0000) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_state <= SETTLE;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.digits      = r_digits;
  assign bus.frame_valid = r_frame_valid;
  assign bus.pat_err     = r_pat_err;
  assign bus.line_err    = r_line_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digit slots on the bus and checks decoded frames
// and error pulses against hand-computed values.
module tb_seg7_scan_decoder;

  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_fv = 0, n_pe = 0, n_le = 0, n_both = 0;

  localparam logic [7:0] S0 = 8'b0011_1111;
  localparam logic [7:0] S1 = 8'b0000_0110;
  localparam logic [7:0] S2 = 8'b0101_1011;
  localparam logic [7:0] S3 = 8'b0100_1111;
  localparam logic [7:0] S4 = 8'b0110_0110;
  localparam logic [7:0] S5 = 8'b0110_1101;
  localparam logic [7:0] S6 = 8'b0111_1101;
  localparam logic [7:0] S7 = 8'b0010_0111;
  localparam logic [7:0] S8 = 8'b0111_1111;
  localparam logic [7:0] S9 = 8'b0110_1111;
  localparam logic [7:0] SB = 8'b0000_0000;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.SETTLE_CYCLES(16), .CNT_W(16)) dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk0 = ~clk0;

  always @(negedge clk0) begin
    if (bus.frame_valid === 1'b1) n_fv++;
    if (bus.pat_err === 1'b1) n_pe++;
    if (bus.line_err === 1'b1) n_le++;
    if (bus.pat_err === 1'b1 && bus.line_err === 1'b1) n_both++;
  end

  task automatic clear_counts();
    n_fv = 0; n_pe = 0; n_le = 0;
  endtask

  task automatic slot(input logic [3:0] l, input logic [7:0] s, input int n);
    bus.line = l;
    bus.seg7 = s;
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    bus.line = 4'b0000;
    bus.seg7 = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    if (bus.digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_digits got %h exp %h", bus.digits, 16'hFFFF); end
    n_assert++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", bus.frame_valid); end
    n_assert++;
    if (bus.pat_err !== 1'b0) begin n_fail++; $display("FAIL reset_pat_err got %b exp 0", bus.pat_err); end
    n_assert++;
    if (bus.line_err !== 1'b0) begin n_fail++; $display("FAIL reset_line_err got %b exp 0", bus.line_err); end
    n_assert++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk0);
    #1;
  endtask

  task automatic test_frame();
    clear_counts();
    slot(4'b0001, S1, 40);
    slot(4'b0010, S2, 40);
    slot(4'b0100, S3 | 8'h80, 40);  // decimal point set: must not affect decode
    slot(4'b1000, S4, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 1) begin n_fail++; $display("FAIL frame_fv_count got %0d exp 1", n_fv); end
    n_assert++;
    if (bus.digits !== 16'h4321) begin n_fail++; $display("FAIL frame_digits got %h exp %h", bus.digits, 16'h4321); end
    n_assert++;
    if (n_pe !== 0 || n_le !== 0) begin n_fail++; $display("FAIL frame_errs got pe=%0d le=%0d exp 0/0", n_pe, n_le); end
    n_assert++;
  endtask

  task automatic test_hold();
    clear_counts();
    slot(4'b0001, S0, 500);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 0) begin n_fail++; $display("FAIL hold_fv_count got %0d exp 0", n_fv); end
    n_assert++;
    if (bus.digits !== 16'h4321) begin n_fail++; $display("FAIL hold_digits got %h exp %h", bus.digits, 16'h4321); end
    n_assert++;
    if (n_pe !== 0 || n_le !== 0) begin n_fail++; $display("FAIL hold_errs got pe=%0d le=%0d exp 0/0", n_pe, n_le); end
    n_assert++;
    // the held 0 on digit 0 must complete a frame with the remaining three digits
    slot(4'b0010, S5, 40);
    slot(4'b0100, S6, 40);
    slot(4'b1000, S7, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 1) begin n_fail++; $display("FAIL hold_followup_fv got %0d exp 1", n_fv); end
    n_assert++;
    if (bus.digits !== 16'h7650) begin n_fail++; $display("FAIL hold_followup_digits got %h exp %h", bus.digits, 16'h7650); end
    n_assert++;
  endtask

  task automatic test_glitch();
    clear_counts();
    for (int i = 0; i < 10; i++) slot(4'b0010, (i % 2 == 0) ? S2 : S3, 10);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 0 || n_pe !== 0 || n_le !== 0) begin
      n_fail++; $display("FAIL glitch_pulses got fv=%0d pe=%0d le=%0d exp 0/0/0", n_fv, n_pe, n_le);
    end
    n_assert++;
    slot(4'b0001, S9, 40);
    slot(4'b0100, S8, 40);
    slot(4'b1000, S7, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 0) begin n_fail++; $display("FAIL glitch_no_digit1 got fv=%0d exp 0", n_fv); end
    n_assert++;
    slot(4'b0010, S1, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 1) begin n_fail++; $display("FAIL glitch_complete_fv got %0d exp 1", n_fv); end
    n_assert++;
    if (bus.digits !== 16'h7819) begin n_fail++; $display("FAIL glitch_digits got %h exp %h", bus.digits, 16'h7819); end
    n_assert++;
  endtask

  task automatic test_errors();
    clear_counts();
    slot(4'b0100, 8'b0100_0000, 40);
    @(negedge clk0);
    if (n_pe !== 1 || n_le !== 0) begin n_fail++; $display("FAIL pat_err_pulse got pe=%0d le=%0d exp 1/0", n_pe, n_le); end
    n_assert++;
    clear_counts();
    slot(4'b0011, S1, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_le !== 1 || n_pe !== 0) begin n_fail++; $display("FAIL line_err_pulse got le=%0d pe=%0d exp 1/0", n_le, n_pe); end
    n_assert++;
    if (n_fv !== 0) begin n_fail++; $display("FAIL err_no_frame got fv=%0d exp 0", n_fv); end
    n_assert++;
    if (bus.digits !== 16'h7819) begin n_fail++; $display("FAIL err_digits got %h exp %h", bus.digits, 16'h7819); end
    n_assert++;
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    slot(4'b0001, S1, 40);
    slot(4'b0010, S2, 40);
    slot(4'b0100, S3, 40);
    bus.line = 4'b0000;
    bus.seg7 = SB;
    rst_n = 1'b0;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    if (bus.digits !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_digits got %h exp %h", bus.digits, 16'hFFFF); end
    n_assert++;
    rst_n = 1'b1;
    slot(4'b0000, SB, 5);
    clear_counts();
    slot(4'b0001, S9, 40);
    slot(4'b0010, S8, 40);
    slot(4'b0100, S7, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 0 || bus.digits !== 16'hFFFF) begin
      n_fail++; $display("FAIL midreset_partial got fv=%0d digits=%h exp 0/ffff", n_fv, bus.digits);
    end
    n_assert++;
    slot(4'b1000, SB, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 1) begin n_fail++; $display("FAIL midreset_fv got %0d exp 1", n_fv); end
    n_assert++;
    if (bus.digits !== 16'hF789) begin n_fail++; $display("FAIL midreset_digits_new got %h exp %h", bus.digits, 16'hF789); end
    n_assert++;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    slot(4'b0010, S5, 40);
    slot(4'b0010, S6, 40);
    slot(4'b0001, S0, 40);
    slot(4'b0100, S1, 40);
    slot(4'b1000, S2, 40);
    slot(4'b0000, SB, 10);
    @(negedge clk0);
    if (n_fv !== 1) begin n_fail++; $display("FAIL overwrite_fv got %0d exp 1", n_fv); end
    n_assert++;
    if (bus.digits[7:4] !== 4'd6) begin n_fail++; $display("FAIL overwrite_digit1 got %h exp 6", bus.digits[7:4]); end
    n_assert++;
    if (bus.digits !== 16'h2160) begin n_fail++; $display("FAIL overwrite_digits got %h exp %h", bus.digits, 16'h2160); end
    n_assert++;
    if (n_both !== 0) begin n_fail++; $display("FAIL both_errs got %0d exp 0", n_both); end
    n_assert++;
  endtask

  initial begin
    bus.line = 4'b0000;
    bus.seg7 = 8'h00;
    test_reset();
    test_frame();
    test_hold();
    test_glitch();
    test_errors();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 4-digit multiplexed 7-segment display bus (one-hot digit select plus segment pattern) that the stopwatch/clock blocks drive.
- Samples the scan bus and waits for it to settle, then converts each segment pattern back to a BCD code.
- Collects the four digits into a frame and presents them atomically.
- Used for on-board loopback self-check of the display path and for feeding the displayed time to other logic.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is captured. Legal range 2..65535.
- CNT_W, 16: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk0  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- seg7  in  8: segment bus. Bit 7 is the decimal point and is ignored. Bits 6:0 are segments g..a.
- line  in  4: digit select, one-hot. Bit i selects digit i.
- digits  out  16: last complete frame. Digit i is in bits [4i+3:4i]. Codes are 0-9, or 4'hF for blank.
- frame_valid  out  1: one-cycle pulse when digits is updated.
- pat_err  out  1: one-cycle pulse when an unrecognized segment pattern is captured.
- line_err  out  1: one-cycle pulse when a settled line has more than one bit set.

Behaviour:
- Interface: one clock, clk0. Reset rst_n is asynchronous and active-low.
- Reset state:
  - digits = 16'hFFFF; frame_valid, pat_err, line_err = 0.
  - Shadow digit registers = 4'hF each; seen mask = 4'b0000.
  - Settle counter = 0; captured flag = 0; synchronizer and previous-sample registers = 0.
  - A reset asserted mid-frame discards any partial frame.
- Input sampling:
  - seg7[6:0] and line pass through a 2-flop synchronizer.
  - A previous-sample register holds the last synchronized value.
- Settle FSM, states IDLE, SETTLE, HELD:
  - IDLE: synchronized line = 0000. Counter is held at 0 and nothing is captured. A nonzero line moves the FSM to SETTLE with counter = 1.
  - SETTLE: when the synchronized {line, seg} equals the previous sample, counter increments. Any difference resets the counter to 1 and the FSM stays in SETTLE (or goes to IDLE if line = 0000).
  - SETTLE exit: when counter reaches SETTLE_CYCLES, one capture is performed (below) and the FSM enters HELD.
  - HELD: no further capture. Any change of line or seg returns the FSM to SETTLE (counter = 1), or to IDLE if line = 0000.
  - Effect: exactly one capture per stable display slot, however long the slot lasts.
- Capture, multi-bit line: line_err pulses. No shadow register or seen bit changes.
- Capture, one-hot line i — decode seg[6:0]:
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4.
  - 1101101→5, 1111101→6, 0100111→7, 1111111→8, 1101111→9.
  - 0000000→4'hF (blank, valid).
  - Any other pattern: pat_err pulses. Shadow i and seen bit i are unchanged.
  - Valid code: shadow i is loaded and seen bit i is set.
- Frame completion:
  - When a valid capture makes seen = 4'b1111, digits is loaded on the next clk0 edge. That load takes shadow[3:0], including the digit just captured.
  - frame_valid pulses on that same edge, and seen clears to 0000.
  - A re-capture of a digit already seen before completion overwrites its shadow value. seen is unchanged.
- Latency: an input change at the pins reaches a shadow update after 2 + SETTLE_CYCLES clk0 cycles. digits and frame_valid follow 1 cycle later.
- Digit order is arbitrary. Any sequence that covers all four digits completes a frame. The scan order on the bus does not matter.
- Error pulses and frame_valid are registered and never last longer than one cycle. A capture produces either pat_err or line_err, never both.

Test Plan:
- Scan line 0001→0010→0100→1000, each held 40 cycles with SETTLE_CYCLES=16, patterns for digits 1, 2, 3, 4 → one frame_valid pulse; digits = 16'h4321; no error pulses.
- Hold line=0001 with pattern 0111111 for 500 cycles after the frame above → exactly one capture, no frame_valid, digits unchanged at 16'h4321.
- Glitch seg7 every 10 cycles while line=0010 (never 16 stable cycles) → no capture; seen unchanged; no pulses.
- Send line=0100 with pattern 1000000 held 40 cycles → pat_err pulses once. Then send line=0011 stable → line_err pulses once. No frame is produced.
- Capture digits 0, 1 and 2 as valid, assert rst_n low for 3 cycles, then send a full frame of 9, 8, 7, blank → digits = 16'hF789 only after all four new captures; digits = 16'hFFFF immediately after reset.
- Send digit 1 twice (values 5 then 6) before digits 0, 2 and 3 → the frame reports 6 in bits [7:4]; one frame_valid pulse.
